// File: rtl/quantization_ctrl_pipe_if.sv
// Zig-zag write bus of the quantization pipeline.
//   d_out            : quantized, saturated coefficient (signed DATA_W)
//   zig_zag_wr_addr  : zig-zag buffer write address
//   zig_zag_wr_en    : write strobe (one cycle per coefficient)
//   sat_flag         : d_out of this write was clamped
//   eof_out          : write of the eof-flagged coefficient
//   blk_done         : one-cycle pulse after the 64th write of a block
//   blk_comp         : with blk_done: 1=Y, 2=Cb, 3=Cr
//   max_not_zero_idx : with blk_done: highest nonzero zig-zag address of the block
// master = quantization controller, slave = zig-zag RAM / entropy coder.
interface quantization_ctrl_pipe_if #(
    parameter int unsigned DATA_W = 12
);
    logic [DATA_W-1:0] d_out;
    logic [5:0]        zig_zag_wr_addr;
    logic              zig_zag_wr_en;
    logic              sat_flag;
    logic              eof_out;
    logic              blk_done;
    logic [1:0]        blk_comp;
    logic [5:0]        max_not_zero_idx;

    modport master (
        output d_out, zig_zag_wr_addr, zig_zag_wr_en, sat_flag, eof_out,
        output blk_done, blk_comp, max_not_zero_idx
    );

    modport slave (
        input d_out, zig_zag_wr_addr, zig_zag_wr_en, sat_flag, eof_out,
        input blk_done, blk_comp, max_not_zero_idx
    );
endinterface

// File: rtl/quantization_ctrl_pipe.sv
// Fully pipelined JPEG quantization controller: one DCT coefficient per clock.
// Drives the quantization ROM and the external float multiplier, converts the
// {mantissa, exponent} product to a saturated signed integer and writes it to
// the zig-zag buffer, with per-block done / component / max-nonzero reporting.
// Ports:
//   clk_in, rst     : clock, synchronous active-high reset
//   valid_d_in      : coefficient enters this cycle (raster order)
//   sof_in, eof_in  : frame start / frame end tags, qualified by valid_d_in
//   factor_sel      : quality table select
//   mult_out        : {mantissa, exponent} from the multiplier
//   quan_rom_in     : quantization word from the 1-cycle synchronous ROM
//   zig_zag_rom_in  : zig-zag position from the ROM
//   rom_rd, rom_addr: ROM read strobe / address
//   quan_val        : quantization factor to the multiplier
//   zz_bus          : zig-zag write bus and block status (master side)
module quantization_ctrl_pipe #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned MANT_W    = 16,
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned Q_W       = 24,
    parameter int unsigned FSEL_W    = 2,
    parameter int unsigned MULT_LAT  = 0,
    parameter int unsigned LUMA_BLKS = 1,
    parameter int unsigned CHROMA_EN = 1
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      valid_d_in,
    input  logic                      sof_in,
    input  logic                      eof_in,
    input  logic [FSEL_W-1:0]         factor_sel,
    input  logic [MANT_W+EXP_W-1:0]   mult_out,
    input  logic [Q_W-1:0]            quan_rom_in,
    input  logic [5:0]                zig_zag_rom_in,
    output logic                      rom_rd,
    output logic [FSEL_W+6:0]         rom_addr,
    output logic [Q_W-1:0]            quan_val,
    quantization_ctrl_pipe_if.master  zz_bus
);

    localparam int unsigned NBLK  = LUMA_BLKS + 2 * CHROMA_EN;
    localparam int unsigned BLK_W = 3;
    // Tag carried alongside each coefficient: {valid, sof, eof, comp[1:0], zz[5:0]}
    localparam int unsigned TAG_W = 11;
    // Wide enough to hold ma << DATA_W without overflow, so huge exponents still clamp
    localparam int unsigned WW    = MANT_W + DATA_W + 1;
    localparam int unsigned SH_W  = $clog2(WW);
    localparam logic signed [WW-1:0] MaxW = {{(MANT_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [WW-1:0] MinW = {{(MANT_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    // Input stage counters
    logic [5:0]       addr_q, addr_d, cur_addr;
    logic [BLK_W-1:0] blk_q, blk_d, cur_blk;
    logic             is_chroma;
    logic [1:0]       comp_in;

    // Pipeline tags
    logic [4:0]       tag1_q, tag1_d;       // {v, sof, eof, comp}
    logic [TAG_W-1:0] tag2_q, tag2_d;
    logic [TAG_W-1:0] tag_m;                // tag aligned with mult_out
    logic [Q_W-1:0]   quan_val_q, quan_val_d;

    // Arithmetic
    logic signed [MANT_W-1:0] ma;
    logic signed [EXP_W-1:0]  ex;
    logic signed [WW-1:0]     ma_w, t_w, r_w;
    logic [SH_W-1:0]          sh;
    int                       exp_i;
    logic [DATA_W-1:0]        res;
    logic                     res_sat;

    // Output stage
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic [5:0]        wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d, sat_q, sat_d, eof_q, eof_d, wr_sof_q, wr_sof_d;
    logic [1:0]        wr_comp_q, wr_comp_d;

    // Block tracker
    logic [5:0]        wr_cnt_q, wr_cnt_d, base_cnt;
    logic [5:0]        max_q, max_d, base_max, new_max;
    logic              blk_done_q, blk_done_d;
    logic [1:0]        blk_comp_q, blk_comp_d;
    logic [5:0]        max_idx_q, max_idx_d;

    // ---------------------------------------------------------------- input stage
    always_comb begin
        cur_addr  = sof_in ? 6'd0 : addr_q;
        cur_blk   = sof_in ? '0 : blk_q;
        is_chroma = (cur_blk >= BLK_W'(LUMA_BLKS));
        if (cur_blk < BLK_W'(LUMA_BLKS)) begin
            comp_in = 2'd1;
        end else if (cur_blk == BLK_W'(LUMA_BLKS)) begin
            comp_in = 2'd2;
        end else begin
            comp_in = 2'd3;
        end

        addr_d = addr_q;
        blk_d  = blk_q;
        if (valid_d_in) begin
            if (eof_in) begin
                addr_d = '0;
                blk_d  = '0;
            end else begin
                addr_d = cur_addr + 6'd1;
                blk_d  = cur_blk;
                if (cur_addr == 6'd63) begin
                    blk_d = (cur_blk == BLK_W'(NBLK - 1)) ? '0 : cur_blk + BLK_W'(1);
                end
            end
        end

        // Outputs forced to 0 under reset and when idle
        rom_rd   = valid_d_in & ~rst;
        rom_addr = rom_rd ? {factor_sel, is_chroma, cur_addr[2:0], cur_addr[5:3]} : '0;

        tag1_d     = {valid_d_in, sof_in, eof_in, comp_in};
        tag2_d     = {tag1_q, zig_zag_rom_in};
        quan_val_d = tag1_q[4] ? quan_rom_in : quan_val_q;
    end

    // ------------------------------------------------ multiplier latency alignment
    if (MULT_LAT == 0) begin : g_no_lat
        assign tag_m = tag2_q;
    end else begin : g_lat
        logic [TAG_W-1:0] dly_q [MULT_LAT];
        always_ff @(posedge clk_in) begin
            if (rst) begin
                for (int i = 0; i < int'(MULT_LAT); i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= tag2_q;
                for (int i = 1; i < int'(MULT_LAT); i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign tag_m = dly_q[MULT_LAT-1];
    end

    // ---------------------------------------------------------------- arithmetic
    always_comb begin
        ma    = $signed(mult_out[MANT_W+EXP_W-1:EXP_W]);
        ex    = $signed(mult_out[EXP_W-1:0]);
        exp_i = int'(ex);
        ma_w  = {{(DATA_W + 1){ma[MANT_W-1]}}, ma};
        sh    = '0;
        t_w   = '0;
        if (exp_i < 0 || ma == '0) begin
            r_w = '0;
        end else if (exp_i >= int'(MANT_W - 1 + DATA_W)) begin
            // Any nonzero mantissa is out of range here; this value is guaranteed to clamp
            r_w = ma_w <<< DATA_W;
        end else if (exp_i >= int'(MANT_W - 1)) begin
            sh  = SH_W'(exp_i - int'(MANT_W - 1));
            r_w = ma_w <<< sh;
        end else begin
            // Round half-up: keep one extra fraction bit, add 1, drop it
            sh  = SH_W'(int'(MANT_W - 1) - exp_i - 1);
            t_w = ma_w >>> sh;
            r_w = $signed(t_w + WW'(1)) >>> 1;
        end

        if (r_w > MaxW) begin
            res     = MaxW[DATA_W-1:0];
            res_sat = 1'b1;
        end else if (r_w < MinW) begin
            res     = MinW[DATA_W-1:0];
            res_sat = 1'b1;
        end else begin
            res     = r_w[DATA_W-1:0];
            res_sat = 1'b0;
        end
    end

    // ------------------------------------------------------ output stage/tracker
    always_comb begin
        wr_en_d   = tag_m[10];
        wr_sof_d  = tag_m[10] & tag_m[9];
        eof_d     = tag_m[10] & tag_m[8];
        sat_d     = tag_m[10] & res_sat;
        d_out_d   = tag_m[10] ? res : d_out_q;
        wr_addr_d = tag_m[10] ? tag_m[5:0] : wr_addr_q;
        wr_comp_d = tag_m[10] ? tag_m[7:6] : wr_comp_q;

        // A sof-tagged write starts a fresh block regardless of the running count
        base_cnt   = wr_sof_q ? 6'd0 : wr_cnt_q;
        base_max   = wr_sof_q ? 6'd0 : max_q;
        new_max    = (d_out_q != '0 && wr_addr_q > base_max) ? wr_addr_q : base_max;
        wr_cnt_d   = wr_cnt_q;
        max_d      = max_q;
        blk_done_d = 1'b0;
        blk_comp_d = blk_comp_q;
        max_idx_d  = max_idx_q;
        if (wr_en_q) begin
            if (base_cnt == 6'd63) begin
                blk_done_d = 1'b1;
                blk_comp_d = wr_comp_q;
                max_idx_d  = new_max;
                wr_cnt_d   = '0;
                max_d      = '0;
            end else begin
                wr_cnt_d = base_cnt + 6'd1;
                max_d    = new_max;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            addr_q     <= '0;
            blk_q      <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            quan_val_q <= '0;
            d_out_q    <= '0;
            wr_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            sat_q      <= 1'b0;
            eof_q      <= 1'b0;
            wr_sof_q   <= 1'b0;
            wr_comp_q  <= '0;
            wr_cnt_q   <= '0;
            max_q      <= '0;
            blk_done_q <= 1'b0;
            blk_comp_q <= '0;
            max_idx_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            blk_q      <= blk_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
            quan_val_q <= quan_val_d;
            d_out_q    <= d_out_d;
            wr_addr_q  <= wr_addr_d;
            wr_en_q    <= wr_en_d;
            sat_q      <= sat_d;
            eof_q      <= eof_d;
            wr_sof_q   <= wr_sof_d;
            wr_comp_q  <= wr_comp_d;
            wr_cnt_q   <= wr_cnt_d;
            max_q      <= max_d;
            blk_done_q <= blk_done_d;
            blk_comp_q <= blk_comp_d;
            max_idx_q  <= max_idx_d;
        end
    end

    assign quan_val                = quan_val_q;
    assign zz_bus.d_out            = d_out_q;
    assign zz_bus.zig_zag_wr_addr  = wr_addr_q;
    assign zz_bus.zig_zag_wr_en    = wr_en_q;
    assign zz_bus.sat_flag         = sat_q;
    assign zz_bus.eof_out          = eof_q;
    assign zz_bus.blk_done         = blk_done_q;
    assign zz_bus.blk_comp         = blk_comp_q;
    assign zz_bus.max_not_zero_idx = max_idx_q;

endmodule

// File: tb/tb_quantization_ctrl_pipe.sv
// Directed testbench for quantization_ctrl_pipe (4:2:0 layout, combinational multiplier).
module tb_quantization_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_d_in, sof_in, eof_in;
    logic [1:0]  factor_sel;
    logic [23:0] mult_out;
    logic [23:0] quan_rom_in = '0;
    logic [5:0]  zig_zag_rom_in = '0;
    logic        rom_rd;
    logic [8:0]  rom_addr;
    logic [23:0] quan_val;

    logic [23:0] m_in = '0, mq1 = '0, mq2 = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [11:0] wd_q[$];
    logic [5:0]  wa_q[$];
    logic        ws_q[$];
    logic        we_q[$];
    int          wc_q[$];
    logic [1:0]  dc_q[$];
    logic [5:0]  dm_q[$];

    quantization_ctrl_pipe_if #(.DATA_W(12)) zz_bus ();

    quantization_ctrl_pipe #(
        .MULT_LAT (0),
        .LUMA_BLKS(4),
        .CHROMA_EN(1)
    ) dut (
        .clk_in        (clk),
        .rst           (rst),
        .valid_d_in    (valid_d_in),
        .sof_in        (sof_in),
        .eof_in        (eof_in),
        .factor_sel    (factor_sel),
        .mult_out      (mult_out),
        .quan_rom_in   (quan_rom_in),
        .zig_zag_rom_in(zig_zag_rom_in),
        .rom_rd        (rom_rd),
        .rom_addr      (rom_addr),
        .quan_val      (quan_val),
        .zz_bus        (zz_bus)
    );

    always #5 clk = ~clk;

    // Zig-zag ROM model: raster r maps to (5*r) mod 64
    function automatic logic [5:0] zz_of(input logic [8:0] a);
        logic [5:0] r;
        r = {a[2:0], a[5:3]};
        return r * 6'd5;
    endfunction

    // Synchronous ROM and a combinational multiplier whose result for the
    // coefficient issued at t is presented at t+2
    always @(posedge clk) begin
        if (rom_rd) begin
            quan_rom_in    <= {15'd0, rom_addr};
            zig_zag_rom_in <= zz_of(rom_addr);
        end
        mq1 <= m_in;
        mq2 <= mq1;
        cyc <= cyc + 1;
    end
    assign mult_out = mq2;

    always @(negedge clk) begin
        if (zz_bus.zig_zag_wr_en) begin
            wd_q.push_back(zz_bus.d_out);
            wa_q.push_back(zz_bus.zig_zag_wr_addr);
            ws_q.push_back(zz_bus.sat_flag);
            we_q.push_back(zz_bus.eof_out);
            wc_q.push_back(cyc);
        end
        if (zz_bus.blk_done) begin
            dc_q.push_back(zz_bus.blk_comp);
            dm_q.push_back(zz_bus.max_not_zero_idx);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [23:0] m);
        valid_d_in = v;
        sof_in     = s;
        eof_in     = e;
        m_in       = m;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic clear_logs();
        wd_q.delete(); wa_q.delete(); ws_q.delete(); we_q.delete(); wc_q.delete();
        dc_q.delete(); dm_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    logic [23:0] arith_m [6];
    logic [11:0] arith_d [6];
    logic        arith_s [6];
    int          chroma_cnt [6];
    int          gaps;
    int          eofs;
    logic [23:0] m;

    initial begin
        arith_m = '{{16'h4000, 8'd3}, {16'h6000, 8'd1}, {16'hA000, 8'd1},
                    {16'h4000, 8'hFF}, {16'h7FFF, 8'd12}, {16'h8000, 8'd11}};
        arith_d = '{12'h004, 12'h002, 12'hFFF, 12'h000, 12'h7FF, 12'h800};
        arith_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset: rst beats a valid input
        rst = 1'b1; valid_d_in = 1'b1; sof_in = 1'b0; eof_in = 1'b0; factor_sel = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rom_rd", rom_rd, 0);
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_wr_en", zz_bus.zig_zag_wr_en, 0);
        check_eq("rst_d_out", zz_bus.d_out, 0);
        check_eq("rst_quan_val", quan_val, 0);
        check_eq("rst_blk", {zz_bus.blk_done, zz_bus.blk_comp, zz_bus.max_not_zero_idx}, 0);
        valid_d_in = 1'b0;
        rst = 1'b0;
        idle(2);

        // Latency / ROM address: raster 10 issued at t
        for (int r = 0; r < 10; r++) drive(1'b1, r == 0, 1'b0, 24'd0);
        valid_d_in = 1'b1; sof_in = 1'b0; eof_in = 1'b0; m_in = 24'd0;
        #1;
        check_eq("lat_rom_rd", rom_rd, 1);
        check_eq("lat_rom_addr", rom_addr, 9'h111);
        @(posedge clk); #1;
        idle(1);                                   // now t+2
        check_eq("lat_quan_val", quan_val, 24'h111);
        idle(1);                                   // now t+3
        check_eq("lat_wr_en", zz_bus.zig_zag_wr_en, 1);
        check_eq("lat_wr_addr", zz_bus.zig_zag_wr_addr, 6'd50);
        idle(1);
        check_eq("lat_wr_en_off", zz_bus.zig_zag_wr_en, 0);
        idle(3);

        // Rounding and saturation
        clear_logs();
        for (int i = 0; i < 6; i++) drive(1'b1, i == 0, 1'b0, arith_m[i]);
        idle(5);
        check_eq("arith_nwr", wd_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("arith_d%0d", i), wd_q[i], arith_d[i]);
            check_eq($sformatf("arith_sat%0d", i), ws_q[i], arith_s[i]);
            check_eq($sformatf("arith_zz%0d", i), wa_q[i], 6'(i * 5));
        end

        // Resync: sof at addr 37
        for (int r = 0; r < 37; r++) drive(1'b1, r == 0, 1'b0, 24'd0);
        valid_d_in = 1'b1; sof_in = 1'b1; m_in = 24'd0;
        #1;
        check_eq("sof_rom_addr", rom_addr, 9'h100);
        @(posedge clk); #1;
        valid_d_in = 1'b1; sof_in = 1'b0;
        #1;
        check_eq("sof_next_addr", rom_addr, 9'h108);
        @(posedge clk); #1;
        idle(5);

        // Full 4:2:0 MCU with eof on the last coefficient
        clear_logs();
        for (int b = 0; b < 6; b++) chroma_cnt[b] = 0;
        for (int i = 0; i < 384; i++) begin
            m = 24'd0;
            if (i == 0 || i == 4 || i == 129) m = {16'h4000, 8'd3};
            valid_d_in = 1'b1; sof_in = (i == 0); eof_in = (i == 383); m_in = m;
            #1;
            if (rom_addr[6]) chroma_cnt[i / 64]++;
            @(posedge clk); #1;
        end
        valid_d_in = 1'b1; sof_in = 1'b0; eof_in = 1'b0; m_in = 24'd0;
        #1;
        check_eq("eof_wrap_addr", rom_addr, 9'h100);
        @(posedge clk); #1;
        idle(8);
        for (int b = 0; b < 6; b++)
            check_eq($sformatf("mcu_chroma_b%0d", b), chroma_cnt[b], (b >= 4) ? 64 : 0);
        check_eq("mcu_nwr", wd_q.size(), 385);
        gaps = 0;
        for (int i = 1; i < 384; i++) if (wc_q[i] != wc_q[i-1] + 1) gaps++;
        check_eq("mcu_gaps", gaps, 0);
        eofs = 0;
        foreach (we_q[i]) if (we_q[i]) eofs++;
        check_eq("mcu_eof_cnt", eofs, 1);
        check_eq("mcu_eof_last", we_q[383], 1);
        check_eq("mcu_ndone", dc_q.size(), 6);
        for (int b = 0; b < 6; b++) begin
            check_eq($sformatf("mcu_comp_b%0d", b), dc_q[b], (b < 4) ? 1 : b - 2);
            check_eq($sformatf("mcu_max_b%0d", b), dm_q[b], (b == 0) ? 20 : (b == 2) ? 5 : 0);
        end
        check_eq("hold_comp", zz_bus.blk_comp, 3);

        // Reset with three coefficients in flight
        clear_logs();
        drive(1'b1, 1'b1, 1'b0, {16'h4000, 8'd3});
        drive(1'b1, 1'b0, 1'b0, {16'h4000, 8'd3});
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, {16'h4000, 8'd3});
        rst = 1'b0;
        valid_d_in = 1'b0; sof_in = 1'b0; m_in = 24'd0;
        #1;
        check_eq("rstf_wr_en", zz_bus.zig_zag_wr_en, 0);
        check_eq("rstf_d_out", zz_bus.d_out, 0);
        check_eq("rstf_quan_val", quan_val, 0);
        check_eq("rstf_rom", {rom_rd, rom_addr}, 0);
        check_eq("rstf_flags", {zz_bus.sat_flag, zz_bus.eof_out, zz_bus.blk_done,
                                zz_bus.zig_zag_wr_addr, zz_bus.blk_comp}, 0);
        idle(6);
        check_eq("rstf_no_writes", wd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quantization_ctrl_pipe.md
Name: quantization_ctrl_pipe

Overview:
Parametrised successor of the JPEG encoder quantization controller. It processes one DCT coefficient per clock, fully pipelined and with no 3-cycle idle/wait/calc gaps. It drives the quantization-table ROM and the external float multiplier, converts the multiplier's mantissa/exponent result to a saturated signed integer, and writes it to the zig-zag buffer. It sits between the DCT output / multiplier and the zig-zag RAM / entropy coder. New relative to the previous block: configurable MCU layout (4:4:4 / 4:2:2 / 4:2:0 / grayscale), per-block done and component tagging, saturation reporting, frame-start resync, and configurable multiplier latency.

Parameters:
DATA_W, 12, output coefficient width (signed).
MANT_W, 16, multiplier mantissa width (signed, value = ma / 2^(MANT_W-1)).
EXP_W, 8, multiplier exponent width (signed two's complement).
Q_W, 24, quantization ROM word width.
FSEL_W, 2, quality factor select width.
MULT_LAT, 0, cycles from quan_val change to matching mult_out (0 = combinational).
LUMA_BLKS, 1, Y blocks per MCU (1, 2 or 4).
CHROMA_EN, 1, 1 = one Cb and one Cr block follow the Y blocks; 0 = grayscale.

Ports:
clk_in  in  1  clock
rst  in  1  reset; synchronous, active-high
valid_d_in  in  1  one coefficient (raster order) enters the multiplier path this cycle
sof_in  in  1  qualified by valid_d_in: this coefficient is raster 0 of Y block 0
eof_in  in  1  qualified by valid_d_in: last coefficient of frame
factor_sel  in  FSEL_W  quality table select
mult_out  in  MANT_W+EXP_W  {mantissa, exponent} from multiplier
quan_rom_in  in  Q_W  ROM quantization word (1-cycle synchronous ROM)
zig_zag_rom_in  in  6  ROM zig-zag position for this coefficient
rom_rd  out  1  ROM read strobe, = valid_d_in
rom_addr  out  FSEL_W+7  {factor_sel, is_chroma, addr[2:0], addr[5:3]}
quan_val  out  Q_W  quant factor to multiplier
d_out  out  DATA_W  quantized coefficient
zig_zag_wr_addr  out  6  zig-zag write address
zig_zag_wr_en  out  1  write strobe
sat_flag  out  1  d_out of this write was clamped
eof_out  out  1  aligned with write of the eof-flagged coefficient
blk_done  out  1  one-cycle pulse after the 64th write of a block
blk_comp  out  2  with blk_done: 1=Y, 2=Cb, 3=Cr
max_not_zero_idx  out  6  with blk_done: highest zig-zag address written nonzero in the block, 0 if none

Behaviour:
- Reset: every output 0; addr=0, blk_cnt=0; all pipeline valid bits cleared. rst mid-block drops in-flight coefficients, so no write occurs after rst. rst has priority over all inputs.
- Counters advance only on valid_d_in:
  - addr (6-bit) increments and wraps 63->0.
  - On wrap, blk_cnt advances through 0..NBLK-1, where NBLK = LUMA_BLKS + 2*CHROMA_EN, then returns to 0.
  - is_chroma = (blk_cnt >= LUMA_BLKS).
  - sof_in forces addr=0, blk_cnt=0 for that coefficient.
  - After an eof-flagged coefficient, both counters are 0.
- Pipeline, with valid_d_in at cycle t:
  - t: rom_addr/rom_rd driven.
  - t+1: ROM outputs sampled.
  - t+2: quan_val and the delayed zig-zag address visible.
  - t+2+MULT_LAT: mult_out consumed.
  - t+3+MULT_LAT: d_out, zig_zag_wr_addr, zig_zag_wr_en, sat_flag, eof_out visible.
  - Back-to-back valids give back-to-back writes; gaps are preserved.
- Arithmetic:
  - exp < 0 gives 0.
  - Otherwise r = ma * 2^(exp-(MANT_W-1)), rounded half-up (add the bit below the LSB).
  - Clamp r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat_flag=1 iff clamped.
  - Must be exact for all exp up to 2^(EXP_W-1)-1; any nonzero ma with large exp saturates.
- Block tracking, in the output stage:
  - Count writes per block.
  - Track the max zig_zag_wr_addr among writes with d_out != 0.
  - On the 64th write, the next cycle pulses blk_done with blk_comp and max_not_zero_idx.
  - The tracker restarts with the next write, including a write in the same cycle as blk_done.
  - Write count and component are resynced by the sof-flagged coefficient.
- blk_comp: Y for luma blocks; the first chroma block is Cb (2), the second is Cr (3).
- max_not_zero_idx, blk_comp: hold between blk_done pulses.
- blk_done, eof_out, sat_flag, zig_zag_wr_en: single-cycle pulses.

Test Plan:
- Latency/ROM: MULT_LAT=0, factor_sel=2, raster index 10 valid at cycle 0 -> rom_addr=9'h111 at cycle 0; zig_zag_wr_en at cycle 3 with zig_zag_wr_addr = ROM value.
- Rounding: mult_out {16'h4000, 8'd3} -> 4; {16'h6000, 8'd1} -> 2; {16'hA000, 8'd1} -> -1 (12'hFFF); exponent 8'hFF -> 0.
- Saturation: {16'h7FFF, 8'd12} -> d_out=2047, sat_flag=1; {16'h8000, 8'd11} -> -2048, sat_flag=0.
- MCU order: LUMA_BLKS=4, CHROMA_EN=1, 6x64 continuous valids -> rom_addr bit 6 = 0 for blocks 0-3, 1 for 4-5; blk_comp = 1,1,1,1,2,3; 384 writes, no gaps.
- Nonzero index: block with nonzero only at raster 0 and the coefficient mapped to zz 20 -> blk_done with max_not_zero_idx=20; all-zero block -> 0; following block starts clean.
- Resync/reset: sof_in mid-block at addr 37 -> next ROM address uses addr 0, Y table; rst asserted with 3 coefficients in flight -> no writes, all outputs 0 the cycle after.
